// File: rtl/bsg_mux_stream_rr.sv
// N valid/ready input channels merged into one registered output channel.
// An internal round-robin or fixed-priority arbiter picks the source; optional packet lock.
module bsg_mux_stream_rr #(
    parameter int width_p   = 8,
    parameter int els_p     = 2,
    parameter int rr_p      = 1,
    parameter int lock_p    = 0,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [els_p-1:0]                v_i,
    input  logic [els_p-1:0][width_p-1:0]   data_i,
    input  logic [els_p-1:0]                last_i,
    output logic [els_p-1:0]                ready_o,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    output logic [lg_els_lp-1:0]            sel_o,
    output logic                            last_o,
    input  logic                            ready_i
);

    logic                 accept;
    logic                 in_xfer;
    logic                 gnt_v;
    logic [lg_els_lp-1:0] gnt_id;
    logic [lg_els_lp-1:0] scan_id;
    logic [lg_els_lp-1:0] ptr_r;
    logic                 lock_v_r;
    logic [lg_els_lp-1:0] lock_id_r;

    // The output register can take a new beat when empty or draining this cycle.
    assign accept = ~v_o | ready_i;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        gnt_v   = 1'b0;
        gnt_id  = '0;
        scan_id = '0;
        if (els_p == 1) begin
            gnt_v = 1'b1;
        end else if (lock_p != 0 && lock_v_r) begin
            gnt_v  = v_i[lock_id_r];
            gnt_id = lock_id_r;
        end else if (rr_p != 0) begin
            for (int i = 1; i <= els_p; i++) begin
                scan_id = lg_els_lp'((int'(ptr_r) + i) % els_p);
                if (!gnt_v && v_i[scan_id]) begin
                    gnt_v  = 1'b1;
                    gnt_id = scan_id;
                end
            end
        end else begin
            for (int i = els_p - 1; i >= 0; i--) begin
                scan_id = lg_els_lp'(i);
                if (v_i[scan_id]) begin
                    gnt_v  = 1'b1;
                    gnt_id = scan_id;
                end
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (!reset_i && accept && gnt_v) begin
            ready_o[gnt_id] = 1'b1;
        end
    end

    assign in_xfer = |(v_i & ready_o);

    always_ff @(posedge clk_i) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (reset_i) begin
            v_o       <= 1'b0;
            data_o    <= '0;
            sel_o     <= '0;
            last_o    <= 1'b0;
            ptr_r     <= lg_els_lp'(els_p - 1);
            lock_v_r  <= 1'b0;
            lock_id_r <= '0;
        end else if (in_xfer) begin
            v_o    <= 1'b1;
            data_o <= data_i[gnt_id];
            sel_o  <= gnt_id;
            last_o <= last_i[gnt_id];
            if (rr_p != 0) begin
                ptr_r <= gnt_id;
            end
            if (lock_p != 0 && els_p > 1) begin
                // Only the locked channel can be granted while locked, so this both sets and clears.
                lock_v_r  <= ~last_i[gnt_id];
                lock_id_r <= gnt_id;
            end
        end else if (v_o && ready_i) begin
            v_o <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    if (width_p < 1) begin : g_width_check
        $error("bsg_mux_stream_rr: width_p must be >= 1");
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(ready_o))
                else $error("bsg_mux_stream_rr: ready_o not one-hot or zero");
            if (lock_p != 0 && lock_v_r && in_xfer) begin
                assert (gnt_id == lock_id_r)
                    else $error("bsg_mux_stream_rr: grant left the locked channel");
            end
        end
    end
`endif

endmodule
